axi4l_cfg_sequencer: RTL and testbench
======================================

AXI4L_CFG_SEQUENCER -- requirements
Module: axi4l_cfg_sequencer

Interface
REQ-001 SHALL have parameter TBL_IDX_W, default 5, config-table index width (max 32 entries).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, response-wait limit in cycles.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: M_AXI_ACLK and M_AXI_ARESET.
REQ-004 M_AXI_ACLK  in  1  sole clock.
REQ-005 M_AXI_ARESET  in  1  async active-high reset.
REQ-006 start  in  1  begin sequence; sampled in IDLE only.
REQ-007 num_entries  in  TBL_IDX_W+1  table entries to write; sampled with start.
REQ-008 done  out  1  one-cycle pulse at sequence end, success or error.
REQ-009 error  out  1  sticky error flag, cleared by next accepted start.
REQ-010 tbl_idx  out  TBL_IDX_W  table read index.
REQ-011 tbl_entry  in  40  {reg_addr[39:32], wdata[31:0]}, valid one cycle after tbl_idx.
REQ-012 perf_snapshot  out  128  {stall, pixels_out, pixels_in, cycles}; cycles in [31:0].
REQ-013 M_AXI_AWADDR  out  8; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
REQ-014 M_AXI_WDATA  out  32; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
REQ-015 M_AXI_BRESP  in  2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
REQ-016 M_AXI_ARADDR  out  8; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
REQ-017 M_AXI_RDATA  in  32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Function
REQ-018 SHALL implement states IDLE, FETCH, WR, WAIT_B, RD, WAIT_R, FIN.
REQ-019 IDLE: start with num_entries>0 -> FETCH, idx=0; with num_entries=0 -> RD, k=0; start outside IDLE is ignored.
REQ-020 FETCH: one cycle; latch tbl_entry into AWADDR/WDATA at exit -> WR.
REQ-021 WR: AWVALID and WVALID assert together; each drops only after its own handshake; both done -> WAIT_B; address and data stay stable while valid.
REQ-022 WAIT_B: BREADY=1; BRESP!=OKAY -> error=1, FIN; otherwise, if idx=num_entries-1 -> RD, k=0, else idx+1 -> FETCH.
REQ-023 RD: ARVALID=1, ARADDR=8'h60+4*k, held until ARREADY -> WAIT_R.
REQ-024 WAIT_R: RREADY=1; on RVALID, RDATA -> perf_snapshot[32k+31:32k]; RRESP!=OKAY -> error=1, FIN; k=3 -> FIN, else k+1 -> RD.
REQ-025 FIN: done=1 for exactly one cycle -> IDLE.
REQ-026 Timeout counter SHALL run only in WAIT_B/WAIT_R, clearing on entry; reaching TIMEOUT_CYCLES -> error=1, FIN. It SHALL never abort WR/RD with a valid pending.
REQ-027 perf_snapshot slices SHALL hold their value until overwritten by a successful R beat.
REQ-028 All outputs SHALL be registered. Read latency from ARREADY to capture is set by the slave; no outstanding transactions beyond one.

Reset
REQ-029 Reset SHALL force IDLE, with all VALID/READY outputs, done, error, tbl_idx, AWADDR, WDATA, ARADDR and perf_snapshot at 0.
REQ-030 Reset mid-transaction SHALL abort immediately, with no done pulse.

Structure
REQ-031 Register offsets (0x00-0x6C), the OKAY code, and the state enum SHALL reside in shared package isp_axi_pkg.
REQ-032 Single module, no sub-modules; table storage is external.

Verification
REQ-033 num_entries=3 with table {00:05},{10:7F},{2C:3}, zero-wait slave -> three writes in order, then four reads; done pulses once and error=0.
REQ-034 AWREADY delayed 4 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds 4 cycles; a single B is accepted.
REQ-035 Reads return 0x64, 0x10, 0x0F, 0x02 -> perf_snapshot=0x00000002_0000000F_00000010_00000064.
REQ-036 BRESP=2'b10 on the second write -> no further AW; FIN with done=1 and error=1; a new start clears error.
REQ-037 BVALID withheld with TIMEOUT_CYCLES=8 -> error asserts 8 cycles after WAIT_B entry; start during busy is ignored.
REQ-038 ARESET asserted during WR -> all valids low asynchronously; state is IDLE and no done pulse occurs.

Source files
------------

// File: rtl/isp_axi_pkg.sv
// Shared definitions for the ISP AXI4-Lite configuration path:
// register map, AXI response codes and the config-sequencer state encoding.
package isp_axi_pkg;

  localparam logic [7:0] REG_CTRL        = 8'h00;
  localparam logic [7:0] REG_STATUS      = 8'h04;
  localparam logic [7:0] REG_IMG_SIZE    = 8'h10;
  localparam logic [7:0] REG_GAIN        = 8'h2C;
  localparam logic [7:0] REG_PERF_CYCLES = 8'h60;
  localparam logic [7:0] REG_PERF_PIX_IN = 8'h64;
  localparam logic [7:0] REG_PERF_PIX_OUT = 8'h68;
  localparam logic [7:0] REG_PERF_STALL  = 8'h6C;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WR,
    ST_WAIT_B,
    ST_RD,
    ST_WAIT_R,
    ST_FIN
  } seq_state_e;

endpackage

// File: rtl/axi4l_cfg_sequencer.sv
// AXI4-Lite master that streams an external config table into the ISP as writes,
// then reads back the four performance counters into a 128-bit snapshot.
module axi4l_cfg_sequencer
  import isp_axi_pkg::*;
#(
  parameter int TBL_IDX_W      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 M_AXI_ACLK,
  input  logic                 M_AXI_ARESET,
  input  logic                 start,
  input  logic [TBL_IDX_W:0]   num_entries,
  output logic                 done,
  output logic                 error,
  output logic [TBL_IDX_W-1:0] tbl_idx,
  input  logic [39:0]          tbl_entry,
  output logic [127:0]         perf_snapshot,
  output logic [7:0]           M_AXI_AWADDR,
  output logic                 M_AXI_AWVALID,
  input  logic                 M_AXI_AWREADY,
  output logic [31:0]          M_AXI_WDATA,
  output logic                 M_AXI_WVALID,
  input  logic                 M_AXI_WREADY,
  input  logic [1:0]           M_AXI_BRESP,
  input  logic                 M_AXI_BVALID,
  output logic                 M_AXI_BREADY,
  output logic [7:0]           M_AXI_ARADDR,
  output logic                 M_AXI_ARVALID,
  input  logic                 M_AXI_ARREADY,
  input  logic [31:0]          M_AXI_RDATA,
  input  logic [1:0]           M_AXI_RRESP,
  input  logic                 M_AXI_RVALID,
  output logic                 M_AXI_RREADY
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] perf_addr(input logic [1:0] k);
    return REG_PERF_CYCLES + {4'h0, k, 2'b00};
  endfunction

  seq_state_e           state_q, state_d;
  logic [TBL_IDX_W-1:0] idx_q, idx_d;
  logic [TBL_IDX_W:0]   num_q, num_d;
  logic [1:0]           k_q, k_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [7:0]           awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                 arvalid_q, arvalid_d, rready_q, rready_d;
  logic                 done_q, done_d, error_q, error_d;
  logic [127:0]         perf_q, perf_d;
  logic                 last_entry;

  assign last_entry = ({1'b0, idx_q} + (TBL_IDX_W+1)'(1)) == num_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    k_d       = k_q;
    tmo_d     = tmo_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = 1'b0;
    error_d   = error_q;
    perf_d    = perf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          num_d   = num_entries;
          if (num_entries != '0) begin
            idx_d   = '0;
            state_d = ST_FETCH;
          end else begin
            k_d       = 2'd0;
            arvalid_d = 1'b1;
            araddr_d  = perf_addr(2'd0);
            state_d   = ST_RD;
          end
        end
      end
      // Table entry is valid during this cycle, so capture it on the way out.
      ST_FETCH: begin
        awaddr_d  = tbl_entry[39:32];
        wdata_d   = tbl_entry[31:0];
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = ST_WR;
      end
      ST_WR: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
          bready_d = 1'b1;
          tmo_d    = '0;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != AXI_RESP_OKAY) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else if (last_entry) begin
            k_d       = 2'd0;
            arvalid_d = 1'b1;
            araddr_d  = perf_addr(2'd0);
            state_d   = ST_RD;
          end else begin
            idx_d   = idx_q + TBL_IDX_W'(1);
            state_d = ST_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          bready_d = 1'b0;
          error_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_FIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RD: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = '0;
          state_d   = ST_WAIT_R;
        end
      end
      // A failed beat leaves the previous snapshot slice untouched.
      ST_WAIT_R: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (M_AXI_RRESP != AXI_RESP_OKAY) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            perf_d[{k_q, 5'd0} +: 32] = M_AXI_RDATA;
            if (k_q == 2'd3) begin
              done_d  = 1'b1;
              state_d = ST_FIN;
            end else begin
              k_d       = k_q + 2'd1;
              arvalid_d = 1'b1;
              araddr_d  = perf_addr(k_q + 2'd1);
              state_d   = ST_RD;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          rready_d = 1'b0;
          error_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_FIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      k_q       <= '0;
      tmo_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      perf_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      k_q       <= k_d;
      tmo_q     <= tmo_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      error_q   <= error_d;
      perf_q    <= perf_d;
    end
  end

  assign done          = done_q;
  assign error         = error_q;
  assign tbl_idx       = idx_q;
  assign perf_snapshot = perf_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4l_cfg_sequencer.sv
// Directed bench for axi4l_cfg_sequencer: a negedge-driven AXI4-Lite slave model
// with logs, and one task per scenario.
module tb_axi4l_cfg_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [5:0]   num_entries;
  logic         done;
  logic         error;
  logic [4:0]   tbl_idx;
  logic [39:0]  tbl_entry;
  logic [127:0] perf_snapshot;
  logic [7:0]   M_AXI_AWADDR;
  logic         M_AXI_AWVALID;
  logic         M_AXI_AWREADY;
  logic [31:0]  M_AXI_WDATA;
  logic         M_AXI_WVALID;
  logic         M_AXI_WREADY;
  logic [1:0]   M_AXI_BRESP;
  logic         M_AXI_BVALID;
  logic         M_AXI_BREADY;
  logic [7:0]   M_AXI_ARADDR;
  logic         M_AXI_ARVALID;
  logic         M_AXI_ARREADY;
  logic [31:0]  M_AXI_RDATA;
  logic [1:0]   M_AXI_RRESP;
  logic         M_AXI_RVALID;
  logic         M_AXI_RREADY;

  logic [39:0]  tbl_mem [32];
  logic [31:0]  rdata_tbl [4];
  logic [7:0]   aw_log [8];
  logic [31:0]  w_log [8];
  logic [7:0]   ar_log [8];
  int aw_lat, w_lat, b_err_idx;
  logic b_withhold;
  int aw_cnt, w_cnt, n_aw, n_w, n_b, n_ar, n_r, aw_hi, w_hi, done_cnt;
  int n_checks, n_pass;

  axi4l_cfg_sequencer #(.TBL_IDX_W(5), .TIMEOUT_CYCLES(8)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .start(start), .num_entries(num_entries),
    .done(done), .error(error), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .perf_snapshot(perf_snapshot),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  assign tbl_entry = tbl_mem[tbl_idx];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model and monitors: all driven and sampled on the falling edge.
  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (M_AXI_AWVALID) begin
        aw_hi++;
        M_AXI_AWREADY = (aw_cnt >= aw_lat - 1);
        if (M_AXI_AWREADY) begin aw_log[n_aw % 8] = M_AXI_AWADDR; n_aw++; end
        aw_cnt++;
      end else begin
        aw_cnt = 0; M_AXI_AWREADY = 0;
      end
      if (M_AXI_WVALID) begin
        w_hi++;
        M_AXI_WREADY = (w_cnt >= w_lat - 1);
        if (M_AXI_WREADY) begin w_log[n_w % 8] = M_AXI_WDATA; n_w++; end
        w_cnt++;
      end else begin
        w_cnt = 0; M_AXI_WREADY = 0;
      end
      M_AXI_BVALID = M_AXI_BREADY && !b_withhold;
      if (M_AXI_BVALID) begin
        M_AXI_BRESP = (n_b == b_err_idx) ? 2'b10 : 2'b00;
        n_b++;
      end else M_AXI_BRESP = 2'b00;
      M_AXI_ARREADY = M_AXI_ARVALID;
      if (M_AXI_ARREADY) begin ar_log[n_ar % 8] = M_AXI_ARADDR; n_ar++; end
      M_AXI_RVALID = M_AXI_RREADY;
      if (M_AXI_RVALID) begin M_AXI_RDATA = rdata_tbl[n_r % 4]; n_r++; end
      else M_AXI_RDATA = 32'h0;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  task automatic clear_logs();
    @(posedge clk); #1;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    aw_hi = 0; w_hi = 0; done_cnt = 0;
  endtask

  task automatic start_seq(input int n);
    @(negedge clk);
    start = 1'b1; num_entries = 6'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) $display("FAIL %s_done: done not seen within 400 cycles, wanted a pulse", name);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, done, error} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000",
               {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, done, error});
    else n_pass++;
    n_checks++;
    if ({tbl_idx, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR} !== 53'h0)
      $display("FAIL reset_data: idx %0h aw %0h wd %0h ar %0h want 0", tbl_idx, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR);
    else n_pass++;
    n_checks++;
    if (perf_snapshot !== 128'h0) $display("FAIL reset_perf: got %h want 0", perf_snapshot);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [39:0] exp_wr [3];
    clear_logs();
    exp_wr[0] = {8'h00, 32'h05}; exp_wr[1] = {8'h10, 32'h7F}; exp_wr[2] = {8'h2C, 32'h03};
    start_seq(3);
    wait_done("basic");
    n_checks++;
    if (n_aw !== 3 || n_w !== 3) $display("FAIL basic_wr_count: aw %0d w %0d want 3", n_aw, n_w);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({aw_log[i], w_log[i]} !== exp_wr[i])
        $display("FAIL basic_write%0d: got %h want %h", i, {aw_log[i], w_log[i]}, exp_wr[i]);
      else n_pass++;
    end
    n_checks++;
    if (n_ar !== 4 || {ar_log[0], ar_log[1], ar_log[2], ar_log[3]} !== 32'h6064686C)
      $display("FAIL basic_reads: n %0d addrs %h want 4 / 6064686c", n_ar,
               {ar_log[0], ar_log[1], ar_log[2], ar_log[3]});
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1 || error !== 1'b0)
      $display("FAIL basic_done_err: done_cnt %0d error %b want 1 / 0", done_cnt, error);
    else n_pass++;
    n_checks++;
    if (perf_snapshot !== 128'h00000002_0000000F_00000010_00000064)
      $display("FAIL basic_perf: got %h want 000000020000000f0000001000000064", perf_snapshot);
    else n_pass++;
  endtask

  task automatic test_aw_delay();
    clear_logs();
    aw_lat = 4; w_lat = 1;
    start_seq(1);
    wait_done("awdly");
    n_checks++;
    if (aw_hi !== 4 || w_hi !== 1) $display("FAIL awdly_valid_len: aw %0d w %0d want 4 / 1", aw_hi, w_hi);
    else n_pass++;
    n_checks++;
    if (n_b !== 1 || n_aw !== 1 || error !== 1'b0)
      $display("FAIL awdly_single_b: b %0d aw %0d err %b want 1 / 1 / 0", n_b, n_aw, error);
    else n_pass++;
    aw_lat = 1;
  endtask

  task automatic test_bresp_err();
    clear_logs();
    b_err_idx = 1;
    start_seq(3);
    wait_done("berr");
    b_err_idx = -1;
    n_checks++;
    if (n_aw !== 2 || n_ar !== 0) $display("FAIL berr_traffic: aw %0d ar %0d want 2 / 0", n_aw, n_ar);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1 || error !== 1'b1) $display("FAIL berr_flags: done_cnt %0d error %b want 1 / 1", done_cnt, error);
    else n_pass++;
    n_checks++;
    if (perf_snapshot !== 128'h00000002_0000000F_00000010_00000064)
      $display("FAIL berr_perf_hold: got %h want 000000020000000f0000001000000064", perf_snapshot);
    else n_pass++;
  endtask

  task automatic test_error_clear();
    clear_logs();
    rdata_tbl[0] = 32'h11; rdata_tbl[1] = 32'h22; rdata_tbl[2] = 32'h33; rdata_tbl[3] = 32'h44;
    start_seq(0);
    n_checks++;
    if (error !== 1'b0) $display("FAIL errclr_on_start: error %b want 0", error);
    else n_pass++;
    wait_done("errclr");
    n_checks++;
    if (n_aw !== 0 || n_ar !== 4 || error !== 1'b0)
      $display("FAIL errclr_traffic: aw %0d ar %0d err %b want 0 / 4 / 0", n_aw, n_ar, error);
    else n_pass++;
    n_checks++;
    if (perf_snapshot !== 128'h00000044_00000033_00000022_00000011)
      $display("FAIL errclr_perf: got %h want 00000044000000330000002200000011", perf_snapshot);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit seen;
    clear_logs();
    b_withhold = 1'b1;
    start_seq(1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (M_AXI_BREADY) begin seen = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) $display("FAIL tmo_wait_b: BREADY not seen, wanted 1");
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 2) begin start = 1'b1; num_entries = 6'd5; end
      if (i == 3) start = 1'b0;
    end
    n_checks++;
    if (error !== 1'b0) $display("FAIL tmo_early: error %b at 7 cycles want 0", error);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || done !== 1'b1) $display("FAIL tmo_fire: error %b done %b at 8 cycles want 1 / 1", error, done);
    else n_pass++;
    b_withhold = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (n_aw !== 1 || done_cnt !== 1 || M_AXI_AWVALID !== 1'b0)
      $display("FAIL tmo_busy_start_ignored: aw %0d done_cnt %0d awvalid %b want 1 / 1 / 0",
               n_aw, done_cnt, M_AXI_AWVALID);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_logs();
    aw_lat = 30; w_lat = 30;
    start_seq(1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (M_AXI_AWVALID) begin seen = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) $display("FAIL rstmid_wr: AWVALID not seen, wanted 1");
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b00)
      $display("FAIL rstmid_async: awvalid %b wvalid %b want 0 0", M_AXI_AWVALID, M_AXI_WVALID);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    aw_lat = 1; w_lat = 1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0 || M_AXI_AWVALID !== 1'b0 || M_AXI_ARVALID !== 1'b0 || tbl_idx !== 5'd0)
      $display("FAIL rstmid_idle: done_cnt %0d awv %b arv %b idx %0d want 0 0 0 0",
               done_cnt, M_AXI_AWVALID, M_AXI_ARVALID, tbl_idx);
    else n_pass++;
    n_checks++;
    if (perf_snapshot !== 128'h0 || error !== 1'b0)
      $display("FAIL rstmid_clear: perf %h err %b want 0 / 0", perf_snapshot, error);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    start = 1'b0; num_entries = '0; rst = 1'b1;
    aw_lat = 1; w_lat = 1; b_err_idx = -1; b_withhold = 1'b0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; aw_hi = 0; w_hi = 0; done_cnt = 0;
    for (int i = 0; i < 32; i++) tbl_mem[i] = 40'h0;
    tbl_mem[0] = {8'h00, 32'h05};
    tbl_mem[1] = {8'h10, 32'h7F};
    tbl_mem[2] = {8'h2C, 32'h03};
    rdata_tbl[0] = 32'h64; rdata_tbl[1] = 32'h10; rdata_tbl[2] = 32'h0F; rdata_tbl[3] = 32'h02;
    for (int i = 0; i < 8; i++) begin aw_log[i] = 0; w_log[i] = 0; ar_log[i] = 0; end

    test_reset();
    test_basic();
    test_aw_delay();
    test_bresp_err();
    test_error_clear();
    test_timeout();
    test_reset_mid();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
